imem_loader: RTL and testbench

- Boot-time instruction-memory loader that sits directly upstream of the instruction RAM write port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction RAM at consecutive word addresses.
- Holds the CPU in reset until the image is fully loaded, then releases it.

---
 rtl/imem_loader.sv | 190 +++++++++++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: byte stream -> little-endian words -> IRAM write port.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned memWords  = 100,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_w,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StWrite, StDone, StErr, StChk
  } state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic [3:0]  r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data_w;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_cnt;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_asm;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_xfer;
  logic [15:0] w_cnt;
  logic [15:0] w_idx_next;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_cnt      = {in_data, r_cnt[7:0]};
  assign w_idx_next = r_word_idx + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_in_ready   <= 1'b0;
      r_mem_write  <= 4'h0;
      r_mem_addr   <= 32'h0;
      r_mem_data_w <= 32'h0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= 16'h0;
      r_word_idx   <= 16'h0;
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      // Write strobe is a single-cycle pulse; only DATA re-arms it.
      r_mem_write <= 4'h0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state    <= StHdr0;
            r_in_ready <= 1'b1;
          end
        end
        StHdr0: begin
          if (w_xfer) begin
            r_cnt[7:0] <= in_data;
            r_state    <= StHdr1;
          end
        end
        StHdr1: begin
          if (w_xfer) begin
            r_cnt      <= w_cnt;
            r_word_idx <= 16'h0;
            r_byte_idx <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
            if (w_cnt == 16'h0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= StChk;
`else
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_in_ready <= 1'b0;
`endif
            end else if (32'(w_cnt) > memWords) begin
              r_state    <= StErr;
              r_err      <= 1'b1;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ in_data;
`endif
            unique case (r_byte_idx)
              2'd0: r_asm[7:0]   <= in_data;
              2'd1: r_asm[15:8]  <= in_data;
              2'd2: r_asm[23:16] <= in_data;
              default: begin
                r_state      <= StWrite;
                r_in_ready   <= 1'b0;
                r_mem_write  <= 4'hF;
                r_mem_addr   <= ADDR_BASE + {14'h0, r_word_idx, 2'b00};
                r_mem_data_w <= {in_data, r_asm};
              end
            endcase
          end
        end
        StWrite: begin
          r_word_idx <= w_idx_next;
          if (w_idx_next == r_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state    <= StChk;
            r_in_ready <= 1'b1;
`else
            r_state    <= StDone;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
`endif
          end else begin
            r_state    <= StData;
            r_in_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        StDone: begin
          if (start) begin
            r_state    <= StHdr0;
            r_done     <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        StErr: begin
          if (start) begin
            r_state    <= StHdr0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_data_w = r_mem_data_w;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle-exact vector table plus directed multi-cycle sequences.
// Checksum expectations switch on IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [3:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_w;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(
    .memWords (100),
    .ADDR_BASE(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_data_w(mem_data_w),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] pk(input logic ir, input logic [3:0] mw, input logic [31:0] a,
                                     input logic [31:0] d, input logic h, input logic dn,
                                     input logic e);
    return {ir, mw, a, d, h, dn, e};
  endfunction

  function automatic logic [71:0] outs();
    return {in_ready, mem_write, mem_addr, mem_data_w, cpu_hold, done, err};
  endfunction

  // Write scoreboard: every strobe must match the next expected {addr, data}.
  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t  exp_q[$];
  int   n_writes = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (mem_write != 4'h0) begin
      wr_t e;
      n_writes++;
      check("wr_strobe", 72'(mem_write), 72'(4'hF));
      check("wr_ready_low", 72'(in_ready), 72'(1'b0));
      check("wr_one_cycle", 72'(prev_wr), 72'(1'b0));
      check("wr_expected", 72'(exp_q.size() != 0), 72'(1'b1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr_data", 72'({mem_addr, mem_data_w}), 72'({e.a, e.d}));
      end
    end
    prev_wr = (mem_write != 4'h0);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present a byte; returns at the negedge before the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk); in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 for byte %0h", b);
    end
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      @(negedge clk); in_valid = 1'b0;
    end
  endtask

  task automatic wait_end(input string nm, input logic exp_done, input logic exp_err);
    int n;
    n = 0;
    while (!(done || err) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done_err_hold"}, 72'({done, err, cpu_hold}), 72'({exp_done, exp_err, ~exp_done}));
  endtask

  task automatic load_image(input logic [15:0] cnt, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input bit gaps);
    logic [31:0] w [3];
    logic [7:0]  ck;
    w[0] = w0; w[1] = w1; w[2] = w2;
    ck = 8'h00;
    pulse_start();
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back('{a: 32'(i * 4), d: w[i]});
      for (int j = 0; j < 4; j++) begin
        if (gaps) gap(int'($urandom_range(0, 2)));
        send_byte(w[i][j*8 +: 8]);
        ck = ck ^ w[i][j*8 +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(ck);
`endif
    gap(1);
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic [71:0] exp;
  } vec_t;
  vec_t tbl[15];

  task automatic setv(input int i, input logic st, input logic v, input logic [7:0] d,
                      input logic [71:0] exp);
    tbl[i] = '{st: st, v: v, d: d, exp: exp};
  endtask

  initial begin
    int wbase;

    // Image 02 00 | 13 00 00 00 | 93 00 10 00, bytes back-to-back.
    setv(0,  1, 0, 8'h00, pk(0, 4'h0, 0, 0, 1, 0, 0));
    setv(1,  0, 1, 8'h02, pk(1, 4'h0, 0, 0, 1, 0, 0));
    setv(2,  0, 1, 8'h00, pk(1, 4'h0, 0, 0, 1, 0, 0));
    setv(3,  0, 1, 8'h13, pk(1, 4'h0, 0, 0, 1, 0, 0));
    setv(4,  0, 1, 8'h00, pk(1, 4'h0, 0, 0, 1, 0, 0));
    setv(5,  0, 1, 8'h00, pk(1, 4'h0, 0, 0, 1, 0, 0));
    setv(6,  0, 1, 8'h00, pk(1, 4'h0, 0, 0, 1, 0, 0));
    setv(7,  0, 1, 8'h93, pk(0, 4'hF, 0, 32'h13, 1, 0, 0));
    setv(8,  0, 1, 8'h93, pk(1, 4'h0, 0, 32'h13, 1, 0, 0));
    setv(9,  0, 1, 8'h00, pk(1, 4'h0, 0, 32'h13, 1, 0, 0));
    setv(10, 0, 1, 8'h10, pk(1, 4'h0, 0, 32'h13, 1, 0, 0));
    setv(11, 0, 1, 8'h00, pk(1, 4'h0, 0, 32'h13, 1, 0, 0));
    setv(12, 0, 0, 8'h00, pk(0, 4'hF, 4, 32'h0010_0093, 1, 0, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    setv(13, 0, 1, 8'h90, pk(1, 4'h0, 4, 32'h0010_0093, 1, 0, 0));
    setv(14, 0, 0, 8'h00, pk(0, 4'h0, 4, 32'h0010_0093, 0, 1, 0));
`else
    setv(13, 0, 0, 8'h00, pk(0, 4'h0, 4, 32'h0010_0093, 0, 1, 0));
    setv(14, 0, 0, 8'h00, pk(0, 4'h0, 4, 32'h0010_0093, 0, 1, 0));
`endif

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), pk(0, 4'h0, 0, 0, 1, 0, 0));
    rst = 1'b1;

    exp_q.push_back('{a: 32'h0, d: 32'h0000_0013});
    exp_q.push_back('{a: 32'h4, d: 32'h0010_0093});
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = tbl[i].st; in_valid = tbl[i].v; in_data = tbl[i].d;
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    @(negedge clk); start = 1'b0; in_valid = 1'b0;

    // Empty image.
    wbase = n_writes;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    gap(1);
    check("cnt0_waits_chk", 72'({in_ready, done}), 72'({1'b1, 1'b0}));
    send_byte(8'h00);
`endif
    gap(1);
    check("cnt0_done_now", 72'({done, cpu_hold, in_ready}), 72'({1'b1, 1'b0, 1'b0}));
    gap(2);
    check("cnt0_no_write", 72'(n_writes), 72'(wbase));

    // Oversized image is rejected, then a valid load recovers.
    pulse_start();
    send_byte(8'h65);
    send_byte(8'h00);
    gap(1);
    wait_end("oversize", 1'b0, 1'b1);
    gap(2);
    check("oversize_outs", 72'({err, cpu_hold, in_ready, done}), 72'({4'b1100}));
    check("oversize_no_write", 72'(n_writes), 72'(wbase));
    load_image(16'd1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
    wait_end("after_err", 1'b1, 1'b0);

    // Random in_valid gaps across three words.
    load_image(16'd3, 32'h1234_5678, 32'hA5C3_0F96, 32'h0000_FF01, 1'b1);
    wait_end("gaps", 1'b1, 1'b0);
    check("gaps_writes", 72'(n_writes - wbase), 72'(4));

    // Asynchronous reset after the second data byte.
    wbase = n_writes;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    @(negedge clk); in_valid = 1'b0; rst = 1'b0;
    #1;
    check("midreset_outputs", outs(), pk(0, 4'h0, 0, 0, 1, 0, 0));
    @(negedge clk); rst = 1'b1;
    gap(3);
    check("midreset_idle", 72'({in_ready, done, err, cpu_hold}), 72'({4'b0001}));
    check("midreset_no_write", 72'(n_writes), 72'(wbase));
    load_image(16'd2, 32'h0000_0013, 32'h0010_0093, 32'h0, 1'b0);
    wait_end("restart", 1'b1, 1'b0);
    check("restart_writes", 72'(n_writes - wbase), 72'(2));

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 11^22^33^44 = 44: good checksum, then a wrong one.
    load_image(16'd1, 32'h4433_2211, 32'h0, 32'h0, 1'b0);
    wait_end("chk_good", 1'b1, 1'b0);
    exp_q.push_back('{a: 32'h0, d: 32'h4433_2211});
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h45);
    gap(1);
    wait_end("chk_bad", 1'b0, 1'b1);
`endif

    gap(3);
    check("all_writes_seen", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
